// File: rtl/ex_muldiv_if.sv
// Handshake and data bundle between the EX-stage issue logic and the iterative mul/div unit.
// The pipeline side drives the request; the unit drives status and result.
interface ex_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply or restoring divide on
// latched operand magnitudes, with sign fix-up and a registered result plus done pulse.
module ex_muldiv (
  input logic         clk,
  input logic         rstn,
  ex_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic        sign_a_q, sign_b_q;
  logic [31:0] mag_a_q, mag_b_q;
  logic [63:0] acc_q;
  logic [5:0]  cnt_q;
  logic [31:0] result_q;

  logic        is_div, a_signed, b_signed, sign_a, sign_b;
  logic        div_zero, div_ovf, launch, last_iter;
  logic [31:0] mag_a, mag_b, special_result;

  logic [32:0] mul_sum;
  logic [32:0] div_cand, div_diff;
  logic        div_ge;
  logic [63:0] acc_step, prod;
  logic [31:0] quot, rem, calc_result;

  // Request decode: signedness, magnitudes and the two cases that skip iteration.
  always_comb begin
    is_div   = bus.op[2];
    a_signed = (bus.op == 3'd0) || (bus.op == 3'd1) || (bus.op == 3'd2) ||
               (bus.op == 3'd4) || (bus.op == 3'd6);
    b_signed = (bus.op == 3'd0) || (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    sign_a   = a_signed & bus.src_a[31];
    sign_b   = b_signed & bus.src_b[31];
    mag_a    = sign_a ? (~bus.src_a + 32'd1) : bus.src_a;
    mag_b    = sign_b ? (~bus.src_b + 32'd1) : bus.src_b;
    div_zero = is_div && (bus.src_b == 32'd0);
    div_ovf  = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
               (bus.src_a == 32'h8000_0000) && (bus.src_b == 32'hFFFF_FFFF);
    launch   = (state_q == StIdle) && bus.start && !bus.flush;
    if (div_zero) begin
      special_result = bus.op[1] ? bus.src_a : 32'hFFFF_FFFF;
    end else begin
      special_result = bus.op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration of either datapath; acc_q holds {partial, multiplier/dividend bits}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    div_cand  = acc_q[63:31];
    div_diff  = div_cand - {1'b0, mag_b_q};
    // Candidate is always below 2*divisor, so bit 32 of the difference is the borrow.
    div_ge    = ~div_diff[32];
    if (op_q[2]) begin
      acc_step = {(div_ge ? div_diff[31:0] : div_cand[31:0]), acc_q[30:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[31:1]};
    end
    prod      = (sign_a_q ^ sign_b_q) ? (~acc_step + 64'd1) : acc_step;
    quot      = (sign_a_q ^ sign_b_q) ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
    rem       = sign_a_q ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
    last_iter = (cnt_q == 6'd31);
    unique case (op_q)
      3'd0:                calc_result = prod[31:0];
      3'd1, 3'd2, 3'd3:    calc_result = prod[63:32];
      3'd4, 3'd5:          calc_result = quot;
      default:             calc_result = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = (div_zero || div_ovf) ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (last_iter) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy   = (state_q == StCalc);
    bus.done   = (state_q == StDone);
    bus.result = result_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_q     <= 3'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= 32'd0;
      mag_b_q  <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
    end else if (launch) begin
      op_q     <= bus.op;
      sign_a_q <= sign_a;
      sign_b_q <= sign_b;
      mag_a_q  <= mag_a;
      mag_b_q  <= mag_b;
      acc_q    <= {32'd0, (is_div ? mag_a : mag_b)};
      cnt_q    <= 6'd0;
      if (div_zero || div_ovf) begin
        result_q <= special_result;
      end
    end else if ((state_q == StCalc) && !bus.flush) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 6'd1;
      if (last_iter) begin
        result_q <= calc_result;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed RV32M results, launch/done timing,
// flush, mid-operation reset and continuously held start.
module tb_ex_muldiv;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after a rising edge; that cycle is cycle 0 of the launch.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int exp_done, input logic [31:0] exp, input string tag);
    int          nbusy, first_busy, dcyc, ndone;
    logic [31:0] r;
    nbusy = 0; first_busy = -1; dcyc = -1; ndone = 0; r = 32'd0;
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    for (int c = 1; c <= 40; c++) begin
      step();
      // Scramble operands to show they were latched at launch.
      bus.start = 1'b0; bus.op = ~o; bus.src_a = 32'hDEAD_BEEF; bus.src_b = 32'h1234_5678;
      if (bus.busy) begin
        nbusy++;
        if (first_busy < 0) first_busy = c;
      end
      if (bus.done) begin
        ndone++;
        dcyc = c;
        r = bus.result;
      end
    end
    check({tag, "_done_cycle"}, dcyc, exp_done);
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_busy_cycles"}, nbusy, (exp_done == 33) ? 32 : 0);
    if (exp_done == 33) check({tag, "_first_busy"}, first_busy, 1);
    check({tag, "_result"}, r, exp);
    check({tag, "_held"}, bus.result, exp);
  endtask

  initial begin
    int          ndone, dcyc, nbusy;
    logic [31:0] prev;
    total = 0; bad = 0;
    rstn = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0; bus.flush = 1'b0;
    step();
    step();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 32'h0);
    rstn = 1'b1;
    step();

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, "mul_7xm3");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, "mulhu_ff");
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0000, "mulh_ff");
    run(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'hFFFF_FFFF, "mulhsu_m1x2");
    run(3'd3, 32'h8000_0000, 32'h0000_0004, 33, 32'h0000_0002, "mulhu_big");
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, "div_m7_2");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, "rem_m7_2");
    run(3'd5, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, "divu_big_2");
    run(3'd5, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "divu_by0");
    run(3'd7, 32'd5, 32'd0, 1, 32'd5, "remu_by0");
    run(3'd4, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, "div_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, "rem_ovf");
    run(3'd7, 32'd100, 32'd7, 33, 32'd2, "remu_100_7");

    // Flush in cycle 10 of a MUL; relaunch in cycle 11 must finish in cycle 44.
    prev = 32'd2;
    ndone = 0;
    bus.start = 1'b1; bus.op = 3'd0; bus.src_a = 32'd7; bus.src_b = 32'hFFFF_FFFD;
    for (int c = 1; c <= 10; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.done) ndone++;
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_busy_c11", bus.busy, 0);
    check("flush_no_done", ndone + int'(bus.done), 0);
    check("flush_result_kept", bus.result, prev);
    bus.start = 1'b1; bus.op = 3'd0; bus.src_a = 32'd3; bus.src_b = 32'd5;
    dcyc = -1;
    for (int c = 12; c <= 50; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.done && dcyc < 0) begin
        dcyc = c;
        check("relaunch_result", bus.result, 32'd15);
      end
    end
    check("relaunch_done_cycle", dcyc, 44);

    // Synchronous reset sampled at the end of cycle 15 of a DIV.
    ndone = 0;
    bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'd100; bus.src_b = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      step();
      bus.start = 1'b0;
      if (bus.done) ndone++;
    end
    rstn = 1'b0;
    step();
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_result", bus.result, 32'h0);
    rstn = 1'b1;
    for (int c = 17; c <= 45; c++) begin
      step();
      if (bus.done) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    // start held high: one launch every 34 cycles, DONE-cycle start ignored.
    ndone = 0; dcyc = -1; nbusy = 0;
    bus.start = 1'b1; bus.op = 3'd0; bus.src_a = 32'd6; bus.src_b = 32'd7;
    for (int c = 1; c <= 102; c++) begin
      step();
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        dcyc = c;
        check("held_result", bus.result, 32'd42);
      end
    end
    bus.start = 1'b0;
    check("held_done_count", ndone, 3);
    check("held_last_done", dcyc, 101);
    check("held_busy_cycles", nbusy, 96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ALU operand generators. It consumes the forwarded, source-selected ALU A operand and the matching B operand. It computes all eight RV32M operations over a fixed 32-cycle sequence and returns a registered 32-bit result with a one-cycle `done` pulse. The hazard unit holds the pipeline from `start` until `done`.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `src_a`  in  32  ALU A operand after forwarding and source selection (rs1).
- `src_b`  in  32  ALU B operand after forwarding (rs2).
- `flush`  in  1  abort the current operation (branch mispredict or trap).
- `busy`  out  1  high while iterating (state CALC).
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  32  registered result; held until the next accepted `start`.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `start`=1 and `flush`=0: latch `op`, operand signs and operand magnitudes; clear the 6-bit iteration counter.
  - Special case: div/rem with `src_b`=0 goes to DONE directly.
  - Special case: DIV/REM with `src_a`=0x80000000 and `src_b`=0xFFFFFFFF goes to DONE directly.
  - All other operations go to CALC.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - Signed operands are converted to magnitudes on latch.
- Multiply: radix-2 shift-add on a 64-bit accumulator, one bit per cycle, 32 iterations.
  - If sign_a^sign_b is set, the 64-bit product is two's-complement negated.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide: restoring shift-subtract, one quotient bit per cycle, 32 iterations.
  - The quotient is negated if sign_a^sign_b; the remainder is negated if sign_a.
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
- Divide-by-zero: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = `src_a` unmodified.
- Signed overflow: DIV returns 0x80000000; REM returns 0.
- CALC: counter increments each cycle. After the 32nd iteration (counter = 31), the final sign fix-up is written to `result` and the state moves to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` sampled in DONE is ignored.
- `start` outside IDLE is ignored; operands are not re-latched.
- `flush` in CALC or DONE:
  - Next state is IDLE; `done` is suppressed if the flush arrives in CALC.
  - `result` keeps its previous value.
- `flush` and `start` together in IDLE: no launch.
- Reset mid-operation: same as flush, but `result` is also cleared to 0.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0x00000000; state IDLE; counter 0.
- Normal launch, with `start` high in cycle 0 (IDLE):
  - `busy`=1 in cycles 1–32.
  - `done`=1 in cycle 33.
  - Back in IDLE in cycle 34, where a new `start` is accepted.
- Special cases (div-by-zero, overflow): `done`=1 in cycle 1, `busy` stays 0, back in IDLE in cycle 2.
- `busy` and `done` are register outputs; there are no combinational paths from inputs to outputs.
- `result` changes only on the edge that enters DONE, or on reset.

## Test plan
- MUL `src_a`=7, `src_b`=0xFFFFFFFD (−3), start in cycle 0 -> `busy` high in cycles 1–32; `done` in cycle 33 with `result`=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> `result`=0xFFFFFFFE. MULH of the same operands -> 0x00000000. MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD. REM of the same -> 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- DIVU 5/0 -> `done` in cycle 1 with `result`=0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1.
- MUL launch, `flush` in cycle 10:
  - `busy`=0 from cycle 11; `done` never pulses; `result` unchanged.
  - A new start in cycle 11 completes in cycle 44.
- Reset and `start` behaviour:
  - `rstn`=0 in cycle 15 of a DIV -> all outputs return to reset values; no `done`.
  - `start` held high continuously -> one launch per 34 cycles, with exactly one `done` each.
